// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: stall encodings, FSM states,
// and the default exception vector.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_MULTI = 2'd1,
    ST_FLUSH = 2'd2
  } pc_state_t;

  // Hold bits {mem/wb, ex/mem, id/ex, if/id, pc}
  localparam logic [4:0] STALL_NONE = 5'b00000;
  localparam logic [4:0] STALL_ID   = 5'b00011;
  localparam logic [4:0] STALL_EX   = 5'b00111;
  localparam logic [4:0] STALL_MEM  = 5'b01111;

  localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_0380;

endpackage

// File: rtl/pipe_ctrl_mc_cnt.sv
// Multi-cycle EX down-counter: loads MC_LAT-1 on start, freezes on memory stall,
// and flags the final decrementing cycle as done.
module pipe_ctrl_mc_cnt #(
  parameter int MC_LAT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic freeze,
  input  logic clear,
  output logic busy,
  output logic done
);

  logic [7:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= 8'd0;
    end else if (clear) begin
      count <= 8'd0;
    end else if (load) begin
      count <= 8'(MC_LAT - 1);
    end else if (busy && !freeze) begin
      count <= count - 8'd1;
    end
  end

  assign busy = (count != 8'd0);
  // The mc_start cycle is the first hold cycle, so the last hold is at count==1.
  assign done = busy && !freeze && (count == 8'd1);

endmodule

// File: rtl/pipe_ctrl.sv
// Central pipeline controller: stall merging, multi-cycle EX sequencing and
// exception/eret redirect. Optional stall watchdog under PIPE_CTRL_WDOG_EN.
//
// state    | meaning
// ST_RUN   | normal issue; stalls merged by priority
// ST_MULTI | EX multi-cycle op in progress, counter running
// ST_FLUSH | one bubble cycle after a redirect; squashed requests ignored
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] EXC_VECTOR = ADDR_W'(EXC_VECTOR_DEF),
  parameter int                MC_LAT     = 8,
  parameter int                WDOG_LIMIT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_req_id,
  input  logic              stall_req_ex,
  input  logic              mc_start,
  input  logic              stall_req_mem,
  input  logic              exc_valid,
  input  logic              eret,
  input  logic [ADDR_W-1:0] epc,
  output logic [4:0]        stall,
  output logic              flush,
  output logic              redirect_flag,
  output logic [ADDR_W-1:0] redirect_addr,
  output logic              mc_busy,
  output logic              wdog_timeout
);

  pc_state_t         state, state_nxt;
  logic [4:0]        stall_c;
  logic              flush_c, rflag_c, busy_c;
  logic [ADDR_W-1:0] raddr_c;
  logic              cnt_load, cnt_clear, cnt_busy, cnt_done;

  pipe_ctrl_mc_cnt #(.MC_LAT(MC_LAT)) u_mc_cnt (
    .clk    (clk),
    .rst    (rst),
    .load   (cnt_load),
    .freeze (stall_req_mem),
    .clear  (cnt_clear),
    .busy   (cnt_busy),
    .done   (cnt_done)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_RUN;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    stall_c   = STALL_NONE;
    flush_c   = 1'b0;
    rflag_c   = 1'b0;
    raddr_c   = '0;
    busy_c    = 1'b0;
    cnt_load  = 1'b0;
    cnt_clear = 1'b0;
    case (state)
      ST_RUN: begin
        if (exc_valid || eret) begin
          flush_c   = 1'b1;
          rflag_c   = 1'b1;
          raddr_c   = exc_valid ? EXC_VECTOR : epc;
          state_nxt = ST_FLUSH;
        end else begin
          if (mc_start) begin
            cnt_load  = 1'b1;
            busy_c    = 1'b1;
            state_nxt = ST_MULTI;
          end
          if (stall_req_mem)                  stall_c = STALL_MEM;
          else if (mc_start || stall_req_ex)  stall_c = STALL_EX;
          else if (stall_req_id)              stall_c = STALL_ID;
        end
      end
      ST_MULTI: begin
        if (exc_valid || eret) begin
          flush_c   = 1'b1;
          rflag_c   = 1'b1;
          raddr_c   = exc_valid ? EXC_VECTOR : epc;
          cnt_clear = 1'b1;
          state_nxt = ST_FLUSH;
        end else begin
          busy_c  = cnt_busy;
          stall_c = stall_req_mem ? STALL_MEM : STALL_EX;
          if (cnt_done || !cnt_busy) state_nxt = ST_RUN;
        end
      end
      ST_FLUSH: begin
        flush_c   = 1'b1;
        state_nxt = ST_RUN;
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  // Outputs read as zero for the whole time reset is asserted.
  assign stall         = rst ? stall_c : STALL_NONE;
  assign flush         = rst & flush_c;
  assign redirect_flag = rst & rflag_c;
  assign redirect_addr = rst ? raddr_c : '0;
  assign mc_busy       = rst & busy_c;

`ifdef PIPE_CTRL_WDOG_EN
  logic [15:0] wdog_cnt;
  logic        wdog_flag;
  logic        wdog_hit;

  // wdog_cnt holds previous consecutive stalled cycles; +1 counts this one.
  assign wdog_hit = stall[0] && ((32'(wdog_cnt) + 32'd1) >= 32'(WDOG_LIMIT));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdog_cnt  <= 16'd0;
      wdog_flag <= 1'b0;
    end else begin
      if (!stall[0])               wdog_cnt <= 16'd0;
      else if (wdog_cnt != 16'hFFFF) wdog_cnt <= wdog_cnt + 16'd1;
      if (wdog_hit) wdog_flag <= 1'b1;
    end
  end

  assign wdog_timeout = wdog_flag | wdog_hit;
`else
  logic unused_wdog;
  assign unused_wdog  = (WDOG_LIMIT != 0);
  assign wdog_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus random traffic
// compared against a cycle-level behavioural model. Honours PIPE_CTRL_WDOG_EN.
module tb_pipe_ctrl;

  localparam int MC_LAT = 8;
`ifdef PIPE_CTRL_WDOG_EN
  localparam int  WL      = 16;
  localparam bit  WDOG_ON = 1'b1;
`else
  localparam int  WL      = 1024;
  localparam bit  WDOG_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall_req_id = 0, stall_req_ex = 0, mc_start = 0, stall_req_mem = 0;
  logic        exc_valid = 0, eret = 0;
  logic [31:0] epc = '0;
  logic [4:0]  stall;
  logic        flush, redirect_flag, mc_busy, wdog_timeout;
  logic [31:0] redirect_addr;

  pipe_ctrl #(.ADDR_W(32), .MC_LAT(MC_LAT), .WDOG_LIMIT(WL)) dut (
    .clk(clk), .rst(rst),
    .stall_req_id(stall_req_id), .stall_req_ex(stall_req_ex), .mc_start(mc_start),
    .stall_req_mem(stall_req_mem), .exc_valid(exc_valid), .eret(eret), .epc(epc),
    .stall(stall), .flush(flush), .redirect_flag(redirect_flag),
    .redirect_addr(redirect_addr), .mc_busy(mc_busy), .wdog_timeout(wdog_timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: remaining EX hold cycles, pending flush bubble, watchdog run length.
  int rem = 0;
  bit fl_pend = 0;
  int wrun = 0;
  bit wsticky = 0;
  int busy_seen = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit e, input bit r, input bit ms, input bit sid,
                      input bit sex, input bit smem, input logic [31:0] pc);
    logic [4:0]  es;
    logic        ef, erf, eb, ew, started;
    logic [31:0] ea;
    int          wr;
    @(negedge clk);
    exc_valid = e; eret = r; mc_start = ms;
    stall_req_id = sid; stall_req_ex = sex; stall_req_mem = smem; epc = pc;
    #1;
    es = 5'b0; ef = 0; erf = 0; ea = '0; eb = 0; started = 0;
    if (fl_pend) begin
      ef = 1;
    end else if (e || r) begin
      ef = 1; erf = 1;
      ea = e ? 32'h0000_0380 : pc;
    end else begin
      started = ms && (rem == 0);
      eb = (rem > 0) || started;
      if (smem)           es = 5'b01111;
      else if (eb || sex) es = 5'b00111;
      else if (sid)       es = 5'b00011;
    end
    wr = es[0] ? wrun + 1 : 0;
    ew = WDOG_ON && (wsticky || (wr >= WL));
    chk("stall", 32'(stall), 32'(es));
    chk("flush", 32'(flush), 32'(ef));
    chk("redirect_flag", 32'(redirect_flag), 32'(erf));
    chk("redirect_addr", redirect_addr, ea);
    chk("mc_busy", 32'(mc_busy), 32'(eb));
    chk("wdog_timeout", 32'(wdog_timeout), 32'(ew));
    if (mc_busy === 1'b1) busy_seen++;
    if (fl_pend) fl_pend = 0;
    else if (e || r) begin rem = 0; fl_pend = 1; end
    else if (started) rem = MC_LAT - 1;
    else if (rem > 0 && !smem) rem--;
    wrun = wr;
    wsticky = ew;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 32'h0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_stall"}, 32'(stall), 32'h0);
    chk({tag, "_flush"}, 32'(flush), 32'h0);
    chk({tag, "_rflag"}, 32'(redirect_flag), 32'h0);
    chk({tag, "_raddr"}, redirect_addr, 32'h0);
    chk({tag, "_busy"}, 32'(mc_busy), 32'h0);
    chk({tag, "_wdog"}, 32'(wdog_timeout), 32'h0);
  endtask

  initial begin
    #2;
    check_all_zero("reset");
    @(negedge clk); rst = 1'b1;

    // ID stall for 2 cycles, then ID together with MEM
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 1, 0);
    idle(1);

    // Plain multi-cycle op: MC_LAT busy cycles
    busy_seen = 0;
    step(0, 0, 1, 0, 0, 0, 0);
    idle(10);
    chk("mc_hold_plain", busy_seen, MC_LAT);

    // Memory stall for 3 cycles mid-op extends the hold to MC_LAT+3
    busy_seen = 0;
    step(0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    idle(12);
    chk("mc_hold_memstall", busy_seen, MC_LAT + 3);

    // Exception, with a repeated exc_valid during the flush bubble
    step(1, 0, 0, 0, 0, 0, 0);
    chk("exc_vector", redirect_addr, 32'h0000_0380);
    step(1, 0, 1, 0, 0, 0, 0);
    idle(2);

    // eret together with exc_valid, then eret alone
    step(1, 1, 0, 0, 0, 0, 32'h1000_0040);
    chk("exc_beats_eret", redirect_addr, 32'h0000_0380);
    idle(1);
    step(0, 1, 0, 0, 0, 0, 32'h1000_0040);
    chk("eret_epc", redirect_addr, 32'h1000_0040);
    idle(2);

    // Exception aborts a multi-cycle op
    step(0, 0, 1, 0, 0, 0, 0);
    idle(2);
    step(1, 0, 0, 0, 0, 0, 0);
    idle(3);

    // Reset three cycles after mc_start
    step(0, 0, 1, 0, 0, 0, 0);
    idle(3);
    #2 rst = 1'b0;
    #1 check_all_zero("reset_mid_multi");
    rem = 0; fl_pend = 0; wrun = 0; wsticky = 0;
    @(negedge clk); rst = 1'b1;
    busy_seen = 0;
    step(0, 0, 1, 0, 0, 0, 0);
    idle(10);
    chk("mc_hold_after_reset", busy_seen, MC_LAT);

    // Long memory stall (exercises the watchdog when enabled)
    for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 0, 1, 0);
    idle(2);
`ifdef PIPE_CTRL_WDOG_EN
    chk("wdog_sticky", 32'(wdog_timeout), 32'h1);
`else
    chk("wdog_tied_off", 32'(wdog_timeout), 32'h0);
`endif

    // Random traffic against the model
    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(0, 19) == 0), ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 5) == 0), ($urandom_range(0, 4) == 0), $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central pipeline controller for the 5-stage core.
- Merges stall requests from ID, EX and MEM, and sequences multi-cycle EX operations with an internal down-counter.
- Handles exception/eret redirects: produces the per-stage stall vector, the pipeline flush, and the redirect pair consumed by the PC fetch stage.
- The redirect pair is OR-merged upstream with the ID branch flag/address; the redirect wins.
- Sits beside the pipeline; owns no datapath registers except its own state.

Parameters:
- ADDR_W, 32, address width (matches `ADDR_BUS).
- EXC_VECTOR, 32'h0000_0380, exception handler entry address.
- MC_LAT, 8, EX multi-cycle operation latency in cycles (2..255).
- WDOG_LIMIT, 1024, stall watchdog threshold (optional feature only).

Ports:
- clk  in  1  core clock, all state on posedge.
- rst  in  1  asynchronous reset, active-low (asserted at rst=0).
- stall_req_id  in  1  ID hazard (load-use) request.
- stall_req_ex  in  1  EX single-cycle hold request.
- mc_start  in  1  EX begins a multi-cycle op (1-cycle pulse).
- stall_req_mem  in  1  data RAM busy.
- exc_valid  in  1  MEM-stage exception (1-cycle pulse).
- eret  in  1  MEM-stage return-from-exception (1-cycle pulse).
- epc  in  ADDR_W  return address for eret.
- stall  out  5  hold bits {mem/wb, ex/mem, id/ex, if/id, pc}; bit0 drives stall_pc.
- flush  out  1  clear all pipeline registers to bubbles.
- redirect_flag  out  1  PC must load redirect_addr.
- redirect_addr  out  ADDR_W  redirect target.
- mc_busy  out  1  multi-cycle op in progress.
- wdog_timeout  out  1  sticky watchdog flag (0 when feature compiled out).

Behaviour:
- Reset (rst=0, asynchronous): state=RUN, counter=0. All outputs 0: stall, flush, redirect_flag, redirect_addr, mc_busy, wdog_timeout.
- States: RUN, MULTI, FLUSH. stall/flush/redirect are combinational from state and inputs.
- Request priority, highest first: exc_valid/eret, stall_req_mem, MULTI or mc_start, stall_req_ex, stall_req_id.
- Stall encodings:
  - mem: 5'b01111.
  - MULTI, mc_start or ex: 5'b00111.
  - id: 5'b00011.
  - none: 5'b00000.
- RUN:
  - exc_valid=1: flush=1, redirect_flag=1, redirect_addr=EXC_VECTOR, stall=0; next state FLUSH.
  - eret=1 (no exc_valid): same as above, but redirect_addr=epc. If both exc_valid and eret are high, exc_valid wins.
  - mc_start=1 (no exception): stall=5'b00111, counter loads MC_LAT-1; next state MULTI.
  - Otherwise: stall per priority; stay in RUN.
- MULTI:
  - mc_busy=1 and stall>=5'b00111; stall=5'b01111 if stall_req_mem.
  - Counter decrements each cycle, frozen while stall_req_mem=1.
  - Counter reaches 0: return to RUN; stall=5'b00000 that cycle unless another request is present.
  - Total EX hold = MC_LAT cycles, including the mc_start cycle.
  - exc_valid/eret in MULTI: abort. Counter cleared, mc_busy=0, redirect as in RUN, next state FLUSH.
- FLUSH (exactly 1 cycle):
  - flush=1, stall=0, redirect_flag=0.
  - exc_valid, eret and mc_start are ignored (they come from squashed instructions).
  - Next state RUN.
- mc_start while already in MULTI: ignored.
- redirect_addr is 0 whenever redirect_flag=0.

Optional Feature:
- Macro: PIPE_CTRL_WDOG_EN.
- Defined:
  - A 16-bit counter counts consecutive cycles with stall[0]=1 and clears on any cycle with stall[0]=0.
  - When the count reaches WDOG_LIMIT, wdog_timeout sets and stays set until reset. The counter saturates.
- Undefined: no counter; wdog_timeout is tied to 0.

Decomposition:
- Shared package (pcdef.v / bus.v style defines):
  - stall encodings STALL_NONE, STALL_ID, STALL_EX, STALL_MEM.
  - state encodings for RUN, MULTI, FLUSH.
  - EXC_VECTOR default.
- One natural sub-module: pipe_ctrl_mc_cnt. It holds the MC_LAT down-counter with load/freeze/clear inputs and produces done/busy.

Test Plan:
- Reset mid-MULTI: assert rst=0 three cycles after mc_start → all outputs 0 immediately, state RUN after release; the next mc_start gives a full MC_LAT hold.
- stall_req_id=1 for 2 cycles → stall=5'b00011 for exactly those cycles; with stall_req_mem also high → 5'b01111.
- mc_start with MC_LAT=8 → stall=5'b00111 and mc_busy=1 for 8 cycles, then 0; with stall_req_mem high for 3 cycles mid-op → 11 hold cycles total.
- exc_valid in RUN → same cycle flush=1, redirect_flag=1, redirect_addr=0x380; next cycle flush=1, redirect_flag=0; a repeated exc_valid in that cycle is ignored.
- eret with epc=0x1000_0040 in the same cycle as exc_valid → redirect_addr=0x380. eret alone → 0x1000_0040.
- PIPE_CTRL_WDOG_EN with WDOG_LIMIT=16, stall_req_mem held 20 cycles → wdog_timeout rises on the 16th stalled cycle and stays 1 after the stall releases.
